// File: rtl/vliw_data_memory.sv
// vliw_data_memory
// Multi-port data memory for the VLIW load/store slots. Each port can issue one
// request per cycle: a byte-enabled write or a read with a 1-cycle registered
// response. When several ports write the same word in one cycle, the
// lowest-indexed port wins and the others are dropped and flagged. An optional
// clear sequencer zeroes every word after reset before requests are accepted.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_req_valid  per-port request strobe
//   i_req_we     per-port write (1) / read (0)
//   i_req_addr   per-port word address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   i_req_wdata  per-port write data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   i_req_be     per-port byte enables, bit 0 = byte [7:0]
//   o_ready      requests are accepted this cycle
//   o_rsp_valid  per-port read response valid
//   o_rsp_rdata  per-port read data, held until the next response on that port
//   o_conflict   per-port pulse: this port's write lost a same-address collision
module vliw_data_memory #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned READ_MODE      = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_PORTS-1:0]              i_req_valid,
  input  logic [NUM_PORTS-1:0]              i_req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] i_req_be,
  output logic                              o_ready,
  output logic [NUM_PORTS-1:0]              o_rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [NUM_PORTS-1:0]              o_conflict
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

  typedef enum logic {StClear, StRun} state_e;

  localparam state_e ResetState = (CLEAR_ON_RESET != 0) ? StClear : StRun;

  state_e                          r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]           r_clr_cnt, w_clr_cnt_next;
  logic                            w_clear_we;
  logic                            w_accept;
  logic [DATA_WIDTH-1:0]           r_mem [Depth];

  logic [NUM_PORTS-1:0]            r_rsp_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_rsp_rdata;
  logic [NUM_PORTS-1:0]            r_conflict;

  logic [ADDR_WIDTH-1:0]           w_addr    [NUM_PORTS];
  logic [DATA_WIDTH-1:0]           w_wdata   [NUM_PORTS];
  logic [NumBytes-1:0]             w_be      [NUM_PORTS];
  logic [DATA_WIDTH-1:0]           w_rd_word [NUM_PORTS];
  logic [NUM_PORTS-1:0]            w_wr;
  logic [NUM_PORTS-1:0]            w_rd;
  logic [NUM_PORTS-1:0]            w_drop;
  logic [NUM_PORTS-1:0]            w_win;

  // State register and response/conflict registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ResetState;
      r_clr_cnt   <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_conflict  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_clr_cnt   <= w_clr_cnt_next;
      r_rsp_valid <= w_rd;
      r_conflict  <= w_drop;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_rd[p]) begin
          r_rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] <= w_rd_word[p];
        end
      end
    end
  end

  // Next-state logic for the clear sequencer.
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_clear_we     = 1'b0;
    w_accept       = 1'b0;
    unique case (r_state)
      StClear: begin
        w_clear_we     = ~i_rst;
        w_clr_cnt_next = r_clr_cnt + ADDR_WIDTH'(1);
        if (r_clr_cnt == '1) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        w_accept = ~i_rst;
      end
    endcase
  end

  assign o_ready = (r_state == StRun) & ~i_rst;

  // Per-port decode, collision resolution and read-data selection.
  always_comb begin
    w_wr   = '0;
    w_rd   = '0;
    w_drop = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_addr[p]  = i_req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata[p] = i_req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      w_be[p]    = i_req_be[p*NumBytes +: NumBytes];
      w_wr[p]    = w_accept & i_req_valid[p] & i_req_we[p];
      w_rd[p]    = w_accept & i_req_valid[p] & ~i_req_we[p];
    end
    // A writer is dropped if any lower-indexed port writes the same word.
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        if ((q < p) && w_wr[q] && w_wr[p] && (w_addr[q] == w_addr[p])) begin
          w_drop[p] = 1'b1;
        end
      end
    end
    w_win = w_wr & ~w_drop;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_rd_word[p] = r_mem[w_addr[p]];
      // Write-first: fold in the (at most one) winning write to this word.
      if (READ_MODE == 1) begin
        for (int q = 0; q < NUM_PORTS; q++) begin
          if (w_win[q] && (w_addr[q] == w_addr[p])) begin
            for (int b = 0; b < NumBytes; b++) begin
              if (w_be[q][b]) begin
                w_rd_word[p][b*8 +: 8] = w_wdata[q][b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Storage array: never reset, only written by the clear sweep or winners.
  always_ff @(posedge i_clk) begin
    if (w_clear_we) begin
      r_mem[r_clr_cnt] <= '0;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (w_win[p] && w_be[p][b]) begin
          r_mem[w_addr[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
        end
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_conflict  = r_conflict;

endmodule

// File: tb/tb_vliw_data_memory.sv
// Testbench for vliw_data_memory: one read-first and one write-first instance
// share stimulus; directed vectors plus randomized traffic against a word-level
// reference model.
module tb_vliw_data_memory;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NP = 2;
  localparam int DEPTH = 16;

  logic           clk;
  logic           rst;
  logic [NP-1:0]  vld;
  logic [NP-1:0]  we;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP*4-1:0]  be;

  logic           ready_rf, ready_wf;
  logic [NP-1:0]  rv_rf, rv_wf;
  logic [NP*DW-1:0] rd_rf, rd_wf;
  logic [NP-1:0]  cf_rf, cf_wf;

  int n_checks = 0;
  int n_errors = 0;

  vliw_data_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .READ_MODE(0), .CLEAR_ON_RESET(1)
  ) u_dut_rf (
    .i_clk(clk), .i_rst(rst), .i_req_valid(vld), .i_req_we(we), .i_req_addr(addr),
    .i_req_wdata(wdata), .i_req_be(be), .o_ready(ready_rf), .o_rsp_valid(rv_rf),
    .o_rsp_rdata(rd_rf), .o_conflict(cf_rf)
  );

  vliw_data_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .READ_MODE(1), .CLEAR_ON_RESET(1)
  ) u_dut_wf (
    .i_clk(clk), .i_rst(rst), .i_req_valid(vld), .i_req_we(we), .i_req_addr(addr),
    .i_req_wdata(wdata), .i_req_be(be), .o_ready(ready_wf), .o_rsp_valid(rv_wf),
    .o_rsp_rdata(rd_wf), .o_conflict(cf_wf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0]        m_mem [DEPTH];
  int                   clr_left = DEPTH;
  logic [NP-1:0][DW-1:0] e_rd_rf = '0;
  logic [NP-1:0][DW-1:0] e_rd_wf = '0;
  logic [NP-1:0]        e_valid = '0;
  logic [NP-1:0]        e_conf = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    vld = '0; we = '0; addr = '0; wdata = '0; be = '0;
  endtask

  // Advance one clock: update the model from the current inputs, then compare
  // every DUT output 1 time unit after the edge.
  task automatic step();
    logic [DW-1:0] nm [DEPTH];
    logic [DW-1:0] mask;
    int            a;
    bit            dropped;
    e_valid = '0;
    e_conf  = '0;
    if (rst) begin
      e_rd_rf  = '0;
      e_rd_wf  = '0;
      clr_left = DEPTH;
    end else if (clr_left > 0) begin
      m_mem[DEPTH - clr_left] = '0;
      clr_left--;
    end else begin
      nm = m_mem;
      for (int p = 0; p < NP; p++) begin
        if (vld[p] && we[p]) begin
          a = int'(addr[p*AW +: AW]);
          dropped = 1'b0;
          for (int q = 0; q < p; q++) begin
            if (vld[q] && we[q] && (addr[q*AW +: AW] == addr[p*AW +: AW])) dropped = 1'b1;
          end
          if (dropped) begin
            e_conf[p] = 1'b1;
          end else begin
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{be[p*4 + b]}};
            nm[a] = (nm[a] & ~mask) | (wdata[p*DW +: DW] & mask);
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (vld[p] && !we[p]) begin
          a = int'(addr[p*AW +: AW]);
          e_valid[p] = 1'b1;
          e_rd_rf[p] = m_mem[a];
          e_rd_wf[p] = nm[a];
        end
      end
      m_mem = nm;
    end
    @(posedge clk);
    #1;
    chk("ready_rf", 32'(ready_rf), 32'((clr_left == 0) && !rst));
    chk("ready_wf", 32'(ready_wf), 32'((clr_left == 0) && !rst));
    chk("rsp_valid_rf", 32'(rv_rf), 32'(e_valid));
    chk("rsp_valid_wf", 32'(rv_wf), 32'(e_valid));
    chk("conflict_rf", 32'(cf_rf), 32'(e_conf));
    chk("conflict_wf", 32'(cf_wf), 32'(e_conf));
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rdata_rf[%0d]", p), rd_rf[p*DW +: DW], e_rd_rf[p]);
      chk($sformatf("rdata_wf[%0d]", p), rd_wf[p*DW +: DW], e_rd_wf[p]);
    end
  endtask

  // Count cycles with ready low, starting from the current sample.
  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (!ready_rf && n < 40) begin
      n++;
      step();
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  we;
    logic [3:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  be0, be1;
    logic [1:0]  x_conf;
    logic [1:0]  x_valid;
    bit          chk_rd;
    int          port;
    logic [31:0] x_rf, x_wf;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'b01, 2'b01, 4'd5, 4'd0, 32'hAABBCCDD, 32'h0, 4'hF, 4'h0, 2'b00, 2'b00, 0, 0,
                32'h0, 32'h0};
    vecs[1] = '{2'b01, 2'b01, 4'd5, 4'd0, 32'h11223344, 32'h0, 4'h5, 4'h0, 2'b00, 2'b00, 0, 0,
                32'h0, 32'h0};
    vecs[2] = '{2'b01, 2'b00, 4'd5, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b01, 1, 0,
                32'hAA22CC44, 32'hAA22CC44};
    vecs[3] = '{2'b11, 2'b11, 4'd3, 4'd3, 32'h12345678, 32'hDEADBEEF, 4'hF, 4'hF, 2'b10, 2'b00,
                0, 0, 32'h0, 32'h0};
    vecs[4] = '{2'b10, 2'b00, 4'd0, 4'd3, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b10, 1, 1,
                32'h12345678, 32'h12345678};
    vecs[5] = '{2'b01, 2'b01, 4'd7, 4'd0, 32'h1, 32'h0, 4'hF, 4'h0, 2'b00, 2'b00, 0, 0,
                32'h0, 32'h0};
    vecs[6] = '{2'b11, 2'b01, 4'd7, 4'd7, 32'h2, 32'h0, 4'hF, 4'h0, 2'b00, 2'b10, 1, 1,
                32'h1, 32'h2};
    vecs[7] = '{2'b01, 2'b00, 4'd7, 4'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b01, 1, 0,
                32'h2, 32'h2};

    idle_inputs();
    rst = 1'b1;
    step();
    step();

    // Clear sweep after reset, then every word reads back as zero.
    rst = 1'b0;
    count_clear("clear_ready_cycles");
    for (int i = 0; i < DEPTH; i++) begin
      vld = 2'b01; we = 2'b00; addr = 8'(i);
      step();
      chk($sformatf("clear_read[%0d]", i), rd_rf[31:0], 32'h0);
    end
    idle_inputs();
    step();

    // Directed vectors: byte enables, collision, read/write same cycle.
    foreach (vecs[i]) begin
      vld = vecs[i].vld; we = vecs[i].we;
      addr = {vecs[i].a1, vecs[i].a0};
      wdata = {vecs[i].d1, vecs[i].d0};
      be = {vecs[i].be1, vecs[i].be0};
      step();
      chk($sformatf("vec%0d_conflict", i), 32'(cf_rf), 32'(vecs[i].x_conf));
      chk($sformatf("vec%0d_valid", i), 32'(rv_rf), 32'(vecs[i].x_valid));
      if (vecs[i].chk_rd) begin
        chk($sformatf("vec%0d_rdata_rf", i), rd_rf[vecs[i].port*DW +: DW], vecs[i].x_rf);
        chk($sformatf("vec%0d_rdata_wf", i), rd_wf[vecs[i].port*DW +: DW], vecs[i].x_wf);
      end
    end
    idle_inputs();
    step();

    // Reset in the same cycle as a read: response dropped, data cleared.
    vld = 2'b01; we = 2'b00; addr = 8'd7; rst = 1'b1;
    step();
    chk("rst_read_valid", 32'(rv_rf), 32'h0);
    chk("rst_read_rdata", rd_rf[31:0], 32'h0);
    idle_inputs();
    rst = 1'b0;
    count_clear("rst_run_clear_cycles");

    // Reset at clear count 9 restarts the full sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear("rst_mid_clear_cycles");

    // Randomized traffic on a narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      vld   = 2'($urandom);
      we    = 2'($urandom);
      addr  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      wdata = {$urandom, $urandom};
      be    = 8'($urandom);
      step();
    end
    idle_inputs();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vliw_data_memory.md
# vliw_data_memory

Synchronous, parametrised multi-port data memory for the VLIW load/store slots. It replaces the untimed task-based memory model with clocked request/response ports, one per issue slot. Each port supports byte-enabled writes and registered reads, and collisions between slots are detected in hardware. An optional clear sequencer zeroes the array after reset, so simulation and synthesis start from a known state.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word-address width; DEPTH = 2**ADDR_WIDTH words.
- NUM_PORTS, 2, number of independent load/store ports (1..4).
- READ_MODE, 0, 0 = read-first (a read sees the old data on a same-address write), 1 = write-first (a read sees the newly merged data).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = contents undefined, ready immediately.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  the single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  request strobe, bit p for port p.
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  word address; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  write data, sliced per port.
- req_be  in  NUM_PORTS*DATA_WIDTH/8  byte enables, sliced per port; bit 0 = byte [7:0].
- ready  out  1  1 = requests are accepted this cycle.
- rsp_valid  out  NUM_PORTS  read data valid, bit per port.
- rsp_rdata  out  NUM_PORTS*DATA_WIDTH  read data, sliced per port; holds its value until the next response on that port.
- conflict  out  NUM_PORTS  1-cycle pulse: this port's write was dropped because of a collision.

## Operation
- FSM states: CLEAR, RUN.
- Reset: state = CLEAR if CLEAR_ON_RESET, else RUN. Clear counter = 0. ready = 0, rsp_valid = 0, rsp_rdata = 0, conflict = 0.
- Reset does not alter array contents; only CLEAR does.
- CLEAR:
  - Writes 0 to word[counter] each cycle, then increments the counter.
  - After writing word DEPTH-1, moves to RUN.
  - ready = 0; all requests are ignored (no write, no response, no conflict).
- RUN:
  - ready = 1.
  - A request is accepted when req_valid[p] = 1.
- Write (req_we = 1): for each byte b with req_be[b] = 1, word[addr] byte b <= wdata byte b. Bytes with req_be = 0 are unchanged. be = 0 is a legal no-op.
- Read (req_we = 0): rsp_valid[p] = 1 and rsp_rdata[p] = word[addr] in the next cycle.
- Write-write collision (two or more ports write the same address in one cycle):
  - The lowest-indexed port wins and its full byte-enable mask is applied.
  - Every other colliding writer is dropped entirely and has its conflict bit pulsed in the next cycle.
  - Writes to different addresses never conflict.
- Read-write, same address, same cycle:
  - READ_MODE = 0: the reader gets the pre-write word.
  - READ_MODE = 1: the reader gets the word after the winning write's byte merge.
- Read-read to the same address: no restriction.
- rst asserted during CLEAR: the counter restarts at 0 and the full sweep is repeated.
- rst asserted during RUN: in-flight responses are discarded (rsp_valid = 0 next cycle). Writes presented in the reset cycle are not performed.

## Timing
- Read latency is exactly 1 cycle: request at edge N, rsp_valid/rsp_rdata valid after edge N+1. Full throughput, one request per port per cycle.
- Write takes effect at the edge it is sampled. A read issued on the next cycle returns the new data.
- conflict pulses for 1 cycle, aligned with the rsp_valid timing (edge N+1).
- ready:
  - CLEAR_ON_RESET = 1: ready rises DEPTH cycles after the first cycle with rst = 0, i.e. the first accepted request is at cycle DEPTH.
  - CLEAR_ON_RESET = 0: ready = 1 on the first cycle after rst deasserts.
- rsp_rdata does not change when rsp_valid = 0.
- Address is used as-is: DEPTH is a power of two, so there is no out-of-range case.

## Test plan
Bench configuration: DATA_WIDTH = 32, ADDR_WIDTH = 4, NUM_PORTS = 2.
- Clear:
  - Stimulus: CLEAR_ON_RESET = 1, release rst, then read all 16 addresses on port 0.
  - Required: ready = 0 for exactly 16 cycles, then 1; every read returns 0x00000000 one cycle after its request.
- Byte enables:
  - Stimulus: write 0xAABBCCDD to address 5 with be = 1111, then 0x11223344 with be = 0101, then read address 5.
  - Required: read returns 0xAA22CC44.
- Write collision:
  - Stimulus: port 0 writes 0x12345678 and port 1 writes 0xDEADBEEF to address 3 in the same cycle, then read address 3.
  - Required: conflict = 10 for one cycle; read returns 0x12345678.
- Read-write same cycle, address 7 holding 0x1:
  - Stimulus: port 0 writes 0x2 while port 1 reads address 7.
  - Required: READ_MODE = 0 returns 0x1; READ_MODE = 1 returns 0x2.
- Reset mid-clear:
  - Stimulus: assert rst at clear count 9 for 1 cycle.
  - Required: ready stays 0 for 16 further cycles after rst deasserts.
- Reset mid-read:
  - Stimulus: issue a read, assert rst in the same cycle.
  - Required: rsp_valid = 0 next cycle and rsp_rdata = 0.
